ins_mem_access: RTL and testbench

- Memory-access stage (stage 4), between the EX/MEM register and the write-back stage.
- Runs loads and stores against the data memory over a req/ack handshake; formats load data (byte/half/word, signed/unsigned) and store strobes.
- Registers results into the MEM/WB outputs that feed write-back.
- Stalls the upstream pipeline while a memory transaction is outstanding.

---
 rtl/ins_mem_access.sv | 112 +++++++++++
 tb/tb_ins_mem_access.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_mem_access.sv
// ins_mem_access: pipeline memory stage with a req/ack data-memory handshake,
// load/store formatting, upstream stall and registered MEM/WB outputs.
module ins_mem_access #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    input  logic [31:0] pc_plus_4_in,
    input  logic [4:0]  rd_addr_in,
    input  logic        reg_write_in,
    input  logic        mem_to_reg_in,
    input  logic        write_from_pc_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [2:0]  funct3_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] read_data_out,
    output logic [31:0] pc_plus_4_out,
    output logic [4:0]  rd_addr_out,
    output logic        reg_write_out,
    output logic        mem_to_reg_out,
    output logic        write_from_pc_out,
    output logic        misaligned_out,
    output logic        bus_err_out
);
    typedef enum logic {IDLE, WAIT_ACK} state_t;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          memop, mis, issue, done, timeout, wb;
    logic [7:0]    lb;
    logic [15:0]   lh;
    logic [31:0]   ld, wd;
    logic [3:0]    ws;

    always_comb begin
        memop = valid_in & (mem_read_in | mem_write_in);
        mis = ((funct3_in[1:0] == 2'b01) & alu_result_in[0]) | (funct3_in[1] & (|alu_result_in[1:0]));
        issue = state == IDLE && memop && !mis;
        done = state == WAIT_ACK && dmem_ack;
        timeout = state == WAIT_ACK && !dmem_ack && cnt == CW'(TIMEOUT_CYCLES - 1);
        wb = (state == IDLE && valid_in && !memop) || done;
        // gated by rst so the stall also reads 0 while reset is held
        stall_out = rst && (state == IDLE ? issue : (!dmem_ack && !timeout));
        state_d = issue ? WAIT_ACK : (done || timeout) ? IDLE : state;
        cnt_d = (state == WAIT_ACK && !done && !timeout) ? cnt + 1'b1 : '0;
        lb = dmem_rdata[{alu_result_in[1:0], 3'b000} +: 8];
        lh = alu_result_in[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        ld = funct3_in[1] ? dmem_rdata :
             funct3_in[0] ? {{16{lh[15] & !funct3_in[2]}}, lh} : {{24{lb[7] & !funct3_in[2]}}, lb};
        wd = funct3_in[1] ? store_data_in :
             funct3_in[0] ? {2{store_data_in[15:0]}} : {4{store_data_in[7:0]}};
        ws = (funct3_in[1] ? 4'b1111 : funct3_in[0] ? 4'b0011 : 4'b0001) << alu_result_in[1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dmem_req          <= 1'b0;
            dmem_we           <= 1'b0;
            dmem_addr         <= '0;
            dmem_wdata        <= '0;
            dmem_wstrb        <= '0;
            alu_result_out    <= '0;
            read_data_out     <= '0;
            pc_plus_4_out     <= '0;
            rd_addr_out       <= '0;
            reg_write_out     <= 1'b0;
            mem_to_reg_out    <= 1'b0;
            write_from_pc_out <= 1'b0;
            misaligned_out    <= 1'b0;
            bus_err_out       <= 1'b0;
        end else begin
            dmem_req <= state_d == WAIT_ACK;
            if (issue) begin
                dmem_we    <= mem_write_in;
                dmem_addr  <= {alu_result_in[31:2], 2'b00};
                dmem_wdata <= wd;
                dmem_wstrb <= mem_write_in ? ws : 4'b0000;
            end
            alu_result_out    <= wb ? alu_result_in : '0;
            read_data_out     <= (done && !mem_write_in) ? ld : '0;
            pc_plus_4_out     <= wb ? pc_plus_4_in : '0;
            rd_addr_out       <= wb ? rd_addr_in : '0;
            reg_write_out     <= wb && reg_write_in;
            mem_to_reg_out    <= wb && mem_to_reg_in;
            write_from_pc_out <= wb && write_from_pc_in;
            misaligned_out    <= state == IDLE && memop && mis;
            bus_err_out       <= timeout;
        end
    end
endmodule

// File: tb/tb_ins_mem_access.sv
// tb_ins_mem_access: randomized and directed checks of ins_mem_access against
// an arithmetic reference model of loads, stores, stalls, misalignment and timeouts.
module tb_ins_mem_access;
    localparam int T = 4;

    logic        clk = 0, rst = 0;
    logic        valid_in = 0, reg_write_in = 0, mem_to_reg_in = 0, write_from_pc_in = 0;
    logic        mem_read_in = 0, mem_write_in = 0, dmem_ack = 0;
    logic [31:0] alu_result_in = 0, store_data_in = 0, pc_plus_4_in = 0, dmem_rdata = 0;
    logic [4:0]  rd_addr_in = 0;
    logic [2:0]  funct3_in = 0;
    logic        dmem_req, dmem_we, stall_out, reg_write_out, mem_to_reg_out, write_from_pc_out;
    logic        misaligned_out, bus_err_out;
    logic [31:0] dmem_addr, dmem_wdata, alu_result_out, read_data_out, pc_plus_4_out;
    logic [3:0]  dmem_wstrb;
    logic [4:0]  rd_addr_out;

    int checks = 0, passes = 0;

    always #5 clk = ~clk;

    ins_mem_access #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .alu_result_in(alu_result_in),
        .store_data_in(store_data_in), .pc_plus_4_in(pc_plus_4_in), .rd_addr_in(rd_addr_in),
        .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
        .write_from_pc_in(write_from_pc_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .funct3_in(funct3_in), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall_out(stall_out), .alu_result_out(alu_result_out), .read_data_out(read_data_out),
        .pc_plus_4_out(pc_plus_4_out), .rd_addr_out(rd_addr_out), .reg_write_out(reg_write_out),
        .mem_to_reg_out(mem_to_reg_out), .write_from_pc_out(write_from_pc_out),
        .misaligned_out(misaligned_out), .bus_err_out(bus_err_out)
    );

    typedef struct packed {
        int          stalls, reqs, wbs, mis_n, berr_n;
        logic        hung, we, req_after, rw, m2r, wfp;
        logic [31:0] addr, wdata, alu, rdat, pc4;
        logic [3:0]  wstrb;
        logic [4:0]  rd;
    } obs_t;

    function automatic logic [31:0] exp_load(logic [2:0] f3, logic [31:0] a, logic [31:0] w);
        int unsigned lane = a % 4;
        int unsigned v;
        if (f3 == 3'd0 || f3 == 3'd4) begin
            v = (w >> (8 * lane)) % 256;
            if (f3 == 3'd0 && v >= 128) v = v - 256;
            return v;
        end
        if (f3 == 3'd1 || f3 == 3'd5) begin
            v = (w >> (16 * (lane / 2))) % 65536;
            if (f3 == 3'd1 && v >= 32768) v = v - 65536;
            return v;
        end
        return w;
    endfunction

    function automatic int unsigned acc_size(logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [31:0] exp_wdata(logic [2:0] f3, logic [31:0] d);
        int unsigned sz = acc_size(f3);
        return sz == 1 ? (d % 256) * 32'h01010101 : sz == 2 ? (d % 65536) * 32'h00010001 : d;
    endfunction

    function automatic logic [3:0] exp_wstrb(logic [2:0] f3, logic [31:0] a);
        int unsigned sz = acc_size(f3);
        return 4'(((1 << sz) - 1) << (sz == 4 ? 0 : a % 4));
    endfunction

    // Drives one EX/MEM slot, answers the request ack_dly cycles after it appears
    // (negative = never), and records what the DUT did until the slot retires.
    task automatic run_txn(input logic v, rd_, wr, rw, m2r, wfp, input logic [2:0] f3,
                           input logic [31:0] addr, sdata, pc4, rdata, input logic [4:0] rd,
                           input int ack_dly, output obs_t o);
        logic stalled, retired = 0;
        o = '0;
        @(negedge clk);
        valid_in = v; mem_read_in = rd_; mem_write_in = wr; reg_write_in = rw;
        mem_to_reg_in = m2r; write_from_pc_in = wfp; funct3_in = f3; alu_result_in = addr;
        store_data_in = sdata; pc_plus_4_in = pc4; rd_addr_in = rd; dmem_rdata = rdata; dmem_ack = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (dmem_req) begin
                o.reqs = o.reqs + 1;
                if (o.reqs == 1) begin
                    o.we = dmem_we; o.addr = dmem_addr; o.wdata = dmem_wdata; o.wstrb = dmem_wstrb;
                end
                if (o.reqs == ack_dly + 1) begin
                    dmem_ack = 1;
                    #1;
                end
            end
            stalled = stall_out;
            if (stalled) o.stalls = o.stalls + 1;
            @(posedge clk);
            #1;
            if (reg_write_out) o.wbs = o.wbs + 1;
            if (misaligned_out) o.mis_n = o.mis_n + 1;
            if (bus_err_out) o.berr_n = o.berr_n + 1;
            if (!stalled) begin
                o.rw = reg_write_out; o.m2r = mem_to_reg_out; o.wfp = write_from_pc_out;
                o.alu = alu_result_out; o.rdat = read_data_out; o.pc4 = pc_plus_4_out; o.rd = rd_addr_out;
                retired = 1;
                break;
            end
            @(negedge clk);
            dmem_ack = 0;
        end
        o.hung = !retired;
        @(negedge clk);
        valid_in = 0; dmem_ack = 0;
        @(posedge clk);
        #1;
        if (reg_write_out) o.wbs = o.wbs + 1;
        if (misaligned_out) o.mis_n = o.mis_n + 1;
        if (bus_err_out) o.berr_n = o.berr_n + 1;
        o.req_after = dmem_req;
    endtask

    task automatic test_reset();
        rst = 0; valid_in = 1; mem_read_in = 1; funct3_in = 3'd2; alu_result_in = 32'h100;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (stall_out !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_out); else passes++;
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb} !== '0)
            $display("FAIL reset_dmem: got req=%b we=%b addr=%h wdata=%h wstrb=%b want all 0",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb);
        else passes++;
        checks++;
        if ({alu_result_out, read_data_out, pc_plus_4_out, rd_addr_out, reg_write_out, mem_to_reg_out,
             write_from_pc_out, misaligned_out, bus_err_out} !== '0)
            $display("FAIL reset_memwb: got alu=%h rdat=%h pc4=%h rd=%0d rw=%b mis=%b berr=%b want all 0",
                     alu_result_out, read_data_out, pc_plus_4_out, rd_addr_out, reg_write_out,
                     misaligned_out, bus_err_out);
        else passes++;
        valid_in = 0; mem_read_in = 0;
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_load_word();
        obs_t o;
        run_txn(1, 1, 0, 1, 1, 0, 3'd2, 32'h100, 0, 32'h44, 32'hDEADBEEF, 5'd5, 2, o);
        checks++;
        if (o.hung || o.stalls != 3) $display("FAIL lw_stall: got %0d cycles (hung=%b) want 3", o.stalls, o.hung); else passes++;
        checks++;
        if (o.addr !== 32'h100 || o.we !== 1'b0) $display("FAIL lw_req: got addr=%h we=%b want 00000100 0", o.addr, o.we); else passes++;
        checks++;
        if (o.rdat !== 32'hDEADBEEF) $display("FAIL lw_data: got %h want deadbeef", o.rdat); else passes++;
        checks++;
        if ({o.m2r, o.rw, o.rd} !== {1'b1, 1'b1, 5'd5})
            $display("FAIL lw_ctrl: got m2r=%b rw=%b rd=%0d want 1 1 5", o.m2r, o.rw, o.rd);
        else passes++;
        checks++;
        if (o.wbs != 1 || o.req_after !== 1'b0) $display("FAIL lw_single_wb: got %0d writebacks req_after=%b want 1 0", o.wbs, o.req_after); else passes++;
    endtask

    task automatic test_load_formats();
        obs_t o;
        logic [2:0]  f3s [3] = '{3'd0, 3'd4, 3'd5};
        logic [31:0] ads [3] = '{32'h103, 32'h103, 32'h102};
        logic [31:0] exps[3] = '{32'hFFFFFF80, 32'h00000080, 32'h00008012};
        for (int i = 0; i < 3; i++) begin
            run_txn(1, 1, 0, 1, 1, 0, f3s[i], ads[i], 0, 0, 32'h80123456, 5'd9, 1, o);
            checks++;
            if (o.hung || o.rdat !== exps[i])
                $display("FAIL load_fmt%0d: got %h (hung=%b) want %h", i, o.rdat, o.hung, exps[i]);
            else passes++;
        end
    endtask

    task automatic test_store();
        obs_t o;
        run_txn(1, 0, 1, 0, 0, 0, 3'd1, 32'h102, 32'h0000ABCD, 0, 32'h12345678, 5'd3, 0, o);
        checks++;
        if ({o.we, o.addr, o.wdata, o.wstrb} !== {1'b1, 32'h100, 32'hABCDABCD, 4'b1100})
            $display("FAIL sh_bus: got we=%b addr=%h wdata=%h wstrb=%b want 1 00000100 abcdabcd 1100",
                     o.we, o.addr, o.wdata, o.wstrb);
        else passes++;
        checks++;
        if (o.hung || o.wbs != 0 || o.rdat !== 0) $display("FAIL sh_wb: got wbs=%0d rdat=%h want 0 0", o.wbs, o.rdat); else passes++;
    endtask

    task automatic test_misaligned();
        obs_t o;
        run_txn(1, 1, 0, 1, 1, 0, 3'd2, 32'h102, 0, 0, 32'hFFFFFFFF, 5'd4, 0, o);
        checks++;
        if (o.reqs != 0 || o.stalls != 0) $display("FAIL mis_noreq: got reqs=%0d stalls=%0d want 0 0", o.reqs, o.stalls); else passes++;
        checks++;
        if (o.mis_n != 1) $display("FAIL mis_pulse: got %0d cycles want 1", o.mis_n); else passes++;
        checks++;
        if (o.wbs != 0) $display("FAIL mis_wb: got %0d writebacks want 0", o.wbs); else passes++;
    endtask

    task automatic test_timeout();
        obs_t o;
        run_txn(1, 1, 0, 1, 1, 0, 3'd2, 32'h200, 0, 0, 32'h11111111, 5'd6, -1, o);
        checks++;
        if (o.hung || o.reqs != T || o.req_after !== 1'b0) $display("FAIL to_req: got %0d cycles req_after=%b want %0d 0", o.reqs, o.req_after, T); else passes++;
        checks++;
        if (o.berr_n != 1 || o.wbs != 0) $display("FAIL to_berr: got berr=%0d wbs=%0d want 1 0", o.berr_n, o.wbs); else passes++;
        checks++;
        if (o.stalls != T) $display("FAIL to_stall: got %0d want %0d", o.stalls, T); else passes++;
        run_txn(1, 0, 0, 1, 0, 0, 3'd0, 32'h55, 0, 32'h80, 0, 5'd7, 0, o);
        checks++;
        if (o.hung || o.stalls != 0 || {o.rw, o.rd, o.alu} !== {1'b1, 5'd7, 32'h55})
            $display("FAIL to_next_alu: got stalls=%0d rw=%b rd=%0d alu=%h want 0 1 7 00000055", o.stalls, o.rw, o.rd, o.alu);
        else passes++;
    endtask

    task automatic test_reset_mid();
        int wbs = 0, reqs = 0;
        @(negedge clk);
        valid_in = 1; mem_read_in = 1; mem_write_in = 0; reg_write_in = 1; funct3_in = 3'd2;
        alu_result_in = 32'h300; rd_addr_in = 5'd8; dmem_ack = 0;
        @(posedge clk);
        @(negedge clk);
        #2;
        rst = 0;
        #1;
        checks++;
        if ({dmem_req, stall_out, reg_write_out} !== 3'b000)
            $display("FAIL rst_mid: got req=%b stall=%b rw=%b want 000", dmem_req, stall_out, reg_write_out);
        else passes++;
        @(negedge clk);
        valid_in = 0; rst = 1; dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (reg_write_out) wbs++;
            if (dmem_req) reqs++;
        end
        dmem_ack = 0;
        checks++;
        if (wbs != 0 || reqs != 0) $display("FAIL rst_late_ack: got wbs=%0d reqs=%0d want 0 0", wbs, reqs); else passes++;
    endtask

    task automatic test_random();
        obs_t o;
        int n_fail;
        for (int i = 0; i < 80; i++) begin
            int unsigned kind = $urandom_range(0, 3);
            int ack_dly = $urandom_range(0, 5);
            logic v = kind != 3, rd_ = kind == 1, wr = kind == 2;
            logic rw = 1'($urandom), m2r = 1'($urandom), wfp = 1'($urandom);
            logic [2:0] f3 = rd_ ? 3'($urandom_range(0, 2)) | (3'($urandom_range(0, 1)) << 2) :
                             3'($urandom_range(0, 2)) | (3'($urandom_range(0, 1)) << 2);
            logic [31:0] addr = $urandom, sd = $urandom, pc4 = $urandom, rdata = $urandom;
            logic [4:0] rd = 5'($urandom);
            logic memop, aligned, tout, comp, retires;
            if (rd_ && f3[1:0] == 2'b10) f3[2] = 0;
            if ($urandom_range(0, 3) != 0) addr = addr - addr % acc_size(f3);
            memop = v && (rd_ || wr);
            aligned = addr % acc_size(f3) == 0;
            tout = memop && aligned && ack_dly >= T;
            comp = memop && aligned && !tout;
            retires = (v && !memop) || comp;
            run_txn(v, rd_, wr, rw, m2r, wfp, f3, addr, sd, pc4, rdata, rd, ack_dly, o);
            n_fail = 0;
            checks++;
            if (o.hung || o.stalls != (comp ? ack_dly + 1 : tout ? T : 0) || o.reqs != o.stalls * 32'(memop && aligned)) begin
                $display("FAIL rnd%0d_stall: got stalls=%0d reqs=%0d hung=%b (comp=%b tout=%b dly=%0d)",
                         i, o.stalls, o.reqs, o.hung, comp, tout, ack_dly);
                n_fail++;
            end else passes++;
            checks++;
            if (o.mis_n != 32'(memop && !aligned) || o.berr_n != 32'(tout) || o.wbs != 32'(retires && rw)) begin
                $display("FAIL rnd%0d_pulses: got mis=%0d berr=%0d wbs=%0d want %0d %0d %0d",
                         i, o.mis_n, o.berr_n, o.wbs, memop && !aligned, tout, retires && rw);
                n_fail++;
            end else passes++;
            if (memop && aligned) begin
                checks++;
                if (o.we !== wr || o.addr !== (addr - addr % 4) ||
                    (wr && (o.wdata !== exp_wdata(f3, sd) || o.wstrb !== exp_wstrb(f3, addr)))) begin
                    $display("FAIL rnd%0d_bus: got we=%b addr=%h wdata=%h wstrb=%b want %b %h %h %b",
                             i, o.we, o.addr, o.wdata, o.wstrb, wr, addr - addr % 4,
                             exp_wdata(f3, sd), exp_wstrb(f3, addr));
                    n_fail++;
                end else passes++;
            end
            checks++;
            if (retires ? ({o.rw, o.m2r, o.wfp, o.rd, o.alu, o.pc4} !== {rw, m2r, wfp, rd, addr, pc4} ||
                           o.rdat !== ((comp && rd_) ? exp_load(f3, addr, rdata) : 32'h0))
                        : (o.rw !== 1'b0 || (!v && o.alu !== 32'h0))) begin
                $display("FAIL rnd%0d_memwb: got rw=%b rd=%0d alu=%h rdat=%h pc4=%h want rw=%b rd=%0d alu=%h rdat=%h pc4=%h",
                         i, o.rw, o.rd, o.alu, o.rdat, o.pc4, retires && rw, rd, addr,
                         (comp && rd_) ? exp_load(f3, addr, rdata) : 32'h0, pc4);
                n_fail++;
            end else passes++;
            if (n_fail != 0) $display("  rnd%0d op: v=%b rd=%b wr=%b f3=%0d addr=%h", i, v, rd_, wr, f3, addr);
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_formats();
        test_store();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
